// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader_pkg
// Brief    : Shared constants for the descriptor-driven program loader.
// Revision : 1.0  initial release
// ============================================================================
package prog_loader_pkg;

  localparam int c_TGT_W = 2;

  localparam logic [1:0] c_TGT_END = 2'b00;
  localparam logic [1:0] c_TGT_IM  = 2'b01;
  localparam logic [1:0] c_TGT_DM  = 2'b10;
  localparam logic [1:0] c_TGT_RSV = 2'b11;

  localparam int c_ST_W = 3;
  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_DFETCH = 3'd1;
  localparam logic [2:0] c_ST_DDEC   = 3'd2;
  localparam logic [2:0] c_ST_COPY   = 3'd3;
  localparam logic [2:0] c_ST_DRAIN  = 3'd4;
  localparam logic [2:0] c_ST_DONE   = 3'd5;
  localparam logic [2:0] c_ST_ERR    = 3'd6;

  localparam logic [1:0] c_ERR_NONE  = 2'd0;
  localparam logic [1:0] c_ERR_TGT   = 2'd1;
  localparam logic [1:0] c_ERR_NOEND = 2'd2;

  // Descriptor layout, MSB first: tgt | src | dst | len
  function automatic int desc_width(input int mem_aw, input int dst_aw, input int len_w);
    return c_TGT_W + mem_aw + dst_aw + len_w;
  endfunction

  function automatic int dst_lsb(input int len_w);
    return len_w;
  endfunction

  function automatic int src_lsb(input int dst_aw, input int len_w);
    return dst_aw + len_w;
  endfunction

  function automatic int tgt_lsb(input int mem_aw, input int dst_aw, input int len_w);
    return mem_aw + dst_aw + len_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/prog_loader_copy.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader_copy
// Brief    : Read/write copy pipeline with word counter and checksum.
// Revision : 1.0  initial release
// ============================================================================
module prog_loader_copy #(
  parameter int MEM_AW = 14,
  parameter int DST_AW = 10,
  parameter int LEN_W  = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic              i_tgt_im,
  input  logic [MEM_AW-1:0] i_src,
  input  logic [DST_AW-1:0] i_dst,
  input  logic [LEN_W-1:0]  i_len,
  input  logic [DATA_W-1:0] i_mem_data,
  output logic              o_rd_en,
  output logic              o_rd_last,
  output logic [MEM_AW-1:0] o_rd_addr,
  output logic              o_wr_valid,
  output logic              o_wr_im,
  output logic [DST_AW-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic [15:0]       o_word_cnt,
  output logic [DATA_W-1:0] o_checksum
);

  logic              r_rd_active;
  logic [MEM_AW-1:0] r_rd_addr;
  logic [LEN_W-1:0]  r_rd_left;
  logic              r_wr_valid;
  logic              r_wr_im;
  logic [DST_AW-1:0] r_wr_addr;
  logic [15:0]       r_word_cnt;
  logic [DATA_W-1:0] r_checksum;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_active <= 1'b0;
      r_rd_addr   <= '0;
      r_rd_left   <= '0;
      r_wr_valid  <= 1'b0;
      r_wr_im     <= 1'b0;
      r_wr_addr   <= '0;
      r_word_cnt  <= '0;
      r_checksum  <= '0;
    end else begin
      // Write trails read by one cycle: data returns the cycle after the strobe
      r_wr_valid <= r_rd_active;
      if (r_wr_valid) begin
        r_wr_addr <= r_wr_addr + DST_AW'(1);
      end
      if (r_rd_active) begin
        r_rd_addr <= r_rd_addr + MEM_AW'(1);
        r_rd_left <= r_rd_left - LEN_W'(1);
        if (r_rd_left == LEN_W'(1)) begin
          r_rd_active <= 1'b0;
        end
      end
      if (i_load) begin
        r_rd_active <= 1'b1;
        r_rd_addr   <= i_src;
        r_rd_left   <= i_len;
        r_wr_addr   <= i_dst;
        r_wr_im     <= i_tgt_im;
      end
      if (i_clear) begin
        r_word_cnt <= '0;
        r_checksum <= '0;
      end else if (r_wr_valid) begin
        if (r_word_cnt != 16'hFFFF) begin
          r_word_cnt <= r_word_cnt + 16'd1;
        end
        r_checksum <= r_checksum + i_mem_data;
      end
    end
  end

  assign o_rd_en    = r_rd_active;
  assign o_rd_last  = r_rd_active && (r_rd_left == LEN_W'(1));
  assign o_rd_addr  = r_rd_addr;
  assign o_wr_valid = r_wr_valid;
  assign o_wr_im    = r_wr_im;
  assign o_wr_addr  = r_wr_addr;
  assign o_wr_data  = i_mem_data;
  assign o_word_cnt = r_word_cnt;
  assign o_checksum = r_checksum;

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader
// Brief    : Descriptor-table sequencer copying backing memory into IM/DM.
// Revision : 1.0  initial release
// ============================================================================
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DESC_AW = 8,
  parameter int MEM_AW  = 14,
  parameter int DST_AW  = 10,
  parameter int LEN_W   = 10,
  parameter int DATA_W  = 32,
  parameter int IMA_W   = 10,
  parameter int DMA_W   = 15,
  localparam int DESC_W = desc_width(MEM_AW, DST_AW, LEN_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [1:0]         err_code,
  output logic [15:0]        word_cnt,
  output logic [DATA_W-1:0]  checksum,
  output logic               rom_enable,
  output logic               rom_read,
  output logic [DESC_AW-1:0] rom_address,
  input  logic [DESC_W-1:0]  rom_out,
  output logic               MEM_en,
  output logic               MEM_read,
  output logic               MEM_write,
  output logic [MEM_AW-1:0]  MEM_addr,
  input  logic [DATA_W-1:0]  MEM_data,
  output logic               IM_enable,
  output logic               IM_write,
  output logic               IM_read,
  output logic [IMA_W-1:0]   IM_address,
  output logic [DATA_W-1:0]  IM_in,
  output logic               DM_enable,
  output logic               DM_write,
  output logic               DM_read,
  output logic [DMA_W-1:0]   DM_address,
  output logic [DATA_W-1:0]  DM_in
);

  localparam int c_DST_LSB = dst_lsb(LEN_W);
  localparam int c_SRC_LSB = src_lsb(DST_AW, LEN_W);
  localparam int c_TGT_LSB = tgt_lsb(MEM_AW, DST_AW, LEN_W);

  logic [c_ST_W-1:0]  r_state;
  logic [DESC_AW-1:0] r_idx;
  logic [1:0]         r_err_code;

  logic [1:0]         w_tgt;
  logic [MEM_AW-1:0]  w_src;
  logic [DST_AW-1:0]  w_dst;
  logic [LEN_W-1:0]   w_len;
  logic               w_clear;
  logic               w_load;
  logic               w_last_idx;
  logic               w_rd_last;
  logic               w_wr_valid;
  logic               w_wr_im;
  logic [DST_AW-1:0]  w_wr_addr;
  logic [DATA_W-1:0]  w_wr_data;

  assign w_tgt      = rom_out[c_TGT_LSB +: c_TGT_W];
  assign w_src      = rom_out[c_SRC_LSB +: MEM_AW];
  assign w_dst      = rom_out[c_DST_LSB +: DST_AW];
  assign w_len      = rom_out[0 +: LEN_W];
  assign w_clear    = (r_state == c_ST_IDLE) && start;
  assign w_load     = (r_state == c_ST_DDEC) && (w_tgt == c_TGT_IM || w_tgt == c_TGT_DM)
                      && (w_len != '0);
  assign w_last_idx = &r_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= c_ST_IDLE;
      r_idx      <= '0;
      r_err_code <= c_ERR_NONE;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (start) begin
            r_idx      <= '0;
            r_err_code <= c_ERR_NONE;
            r_state    <= c_ST_DFETCH;
          end
        end
        c_ST_DFETCH: r_state <= c_ST_DDEC;
        c_ST_DDEC: begin
          if (w_tgt == c_TGT_END) begin
            r_state <= c_ST_DONE;
          end else if (w_tgt == c_TGT_RSV) begin
            r_state    <= c_ST_ERR;
            r_err_code <= c_ERR_TGT;
          end else if (w_len != '0) begin
            r_state <= c_ST_COPY;
          end else if (w_last_idx) begin
            r_state    <= c_ST_ERR;
            r_err_code <= c_ERR_NOEND;
          end else begin
            r_idx   <= r_idx + DESC_AW'(1);
            r_state <= c_ST_DFETCH;
          end
        end
        c_ST_COPY: begin
          if (w_rd_last) begin
            r_state <= c_ST_DRAIN;
          end
        end
        c_ST_DRAIN: begin
          // Running off the table end means no END descriptor was found
          if (w_last_idx) begin
            r_state    <= c_ST_ERR;
            r_err_code <= c_ERR_NOEND;
          end else begin
            r_idx   <= r_idx + DESC_AW'(1);
            r_state <= c_ST_DFETCH;
          end
        end
        c_ST_DONE, c_ST_ERR: begin
          if (!start) begin
            r_state    <= c_ST_IDLE;
            r_err_code <= c_ERR_NONE;
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  prog_loader_copy #(
    .MEM_AW (MEM_AW),
    .DST_AW (DST_AW),
    .LEN_W  (LEN_W),
    .DATA_W (DATA_W)
  ) u_copy (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_clear),
    .i_load     (w_load),
    .i_tgt_im   (w_tgt == c_TGT_IM),
    .i_src      (w_src),
    .i_dst      (w_dst),
    .i_len      (w_len),
    .i_mem_data (MEM_data),
    .o_rd_en    (MEM_en),
    .o_rd_last  (w_rd_last),
    .o_rd_addr  (MEM_addr),
    .o_wr_valid (w_wr_valid),
    .o_wr_im    (w_wr_im),
    .o_wr_addr  (w_wr_addr),
    .o_wr_data  (w_wr_data),
    .o_word_cnt (word_cnt),
    .o_checksum (checksum)
  );

  assign busy        = (r_state == c_ST_DFETCH) || (r_state == c_ST_DDEC) ||
                       (r_state == c_ST_COPY)   || (r_state == c_ST_DRAIN);
  assign done        = (r_state == c_ST_DONE);
  assign error       = (r_state == c_ST_ERR);
  assign err_code    = r_err_code;
  assign rom_enable  = (r_state == c_ST_DFETCH);
  assign rom_read    = rom_enable;
  assign rom_address = r_idx;
  assign MEM_read    = MEM_en;
  assign MEM_write   = 1'b0;

  assign IM_enable   = w_wr_valid && w_wr_im;
  assign IM_write    = IM_enable;
  assign IM_read     = 1'b0;
  assign IM_address  = IMA_W'(w_wr_addr);
  assign IM_in       = IM_enable ? w_wr_data : '0;
  assign DM_enable   = w_wr_valid && !w_wr_im;
  assign DM_write    = DM_enable;
  assign DM_read     = 1'b0;
  assign DM_address  = DMA_W'(w_wr_addr);
  assign DM_in       = DM_enable ? w_wr_data : '0;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_loader
// Brief    : Randomised self-checking bench for prog_loader against a table walker.
// Revision : 1.0  initial release
// ============================================================================
module tb_prog_loader;

  localparam int DESC_W = 36;
  localparam int DATA_W = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, error;
  logic [1:0]  err_code;
  logic [15:0] word_cnt;
  logic [31:0] checksum;
  logic        rom_enable, rom_read;
  logic [7:0]  rom_address;
  logic [35:0] rom_out;
  logic        MEM_en, MEM_read, MEM_write;
  logic [13:0] MEM_addr;
  logic [31:0] MEM_data;
  logic        IM_enable, IM_write, IM_read;
  logic [9:0]  IM_address;
  logic [31:0] IM_in;
  logic        DM_enable, DM_write, DM_read;
  logic [14:0] DM_address;
  logic [31:0] DM_in;

  prog_loader dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
    .err_code(err_code), .word_cnt(word_cnt), .checksum(checksum),
    .rom_enable(rom_enable), .rom_read(rom_read), .rom_address(rom_address), .rom_out(rom_out),
    .MEM_en(MEM_en), .MEM_read(MEM_read), .MEM_write(MEM_write), .MEM_addr(MEM_addr),
    .MEM_data(MEM_data),
    .IM_enable(IM_enable), .IM_write(IM_write), .IM_read(IM_read), .IM_address(IM_address),
    .IM_in(IM_in),
    .DM_enable(DM_enable), .DM_write(DM_write), .DM_read(DM_read), .DM_address(DM_address),
    .DM_in(DM_in)
  );

  always #5 clk = ~clk;

  logic [DESC_W-1:0] rom [256];
  logic [DATA_W-1:0] mem [16384];
  logic [47:0]       wr_q [$];
  logic [13:0]       rd_q [$];
  int                bad_strobe = 0;

  logic [47:0] exp_wr [$];
  logic [13:0] exp_rd [$];
  int          exp_cycles, exp_cnt;
  logic        exp_done;
  logic [1:0]  exp_code;
  logic [31:0] exp_sum;

  int n_cmp = 0;
  int n_bad = 0;

  // Backing ROM/memory with one-cycle read latency; target writes are logged
  always @(posedge clk) begin
    if (rst) begin
      rom_out  <= '0;
      MEM_data <= '0;
    end else begin
      if (rom_enable && rom_read) rom_out <= rom[rom_address];
      if (MEM_en && MEM_read) begin
        MEM_data <= mem[MEM_addr];
        rd_q.push_back(MEM_addr);
      end
    end
    if (IM_enable && IM_write) wr_q.push_back({1'b1, 5'd0, IM_address, IM_in});
    if (DM_enable && DM_write) wr_q.push_back({1'b0, DM_address, DM_in});
    if ((IM_enable && DM_enable) || MEM_write || IM_read || DM_read ||
        (IM_enable != IM_write) || (DM_enable != DM_write) ||
        (rom_enable != rom_read) || (MEM_en != MEM_read))
      bad_strobe++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] desc(input logic [1:0] t, input logic [13:0] s,
                                       input logic [9:0] d, input logic [9:0] l);
    return {t, s, d, l};
  endfunction

  // Walk the table the way the loader is meant to: copy words, accumulate cost
  task automatic model();
    int idx, cyc, src, dst, len, a, w;
    logic [1:0]  t;
    logic [35:0] d;
    exp_wr.delete();
    exp_rd.delete();
    exp_sum = 0;
    exp_cnt = 0;
    idx = 0;
    cyc = 1;
    forever begin
      d   = rom[idx];
      t   = d[35:34];
      src = int'(d[33:20]);
      dst = int'(d[19:10]);
      len = int'(d[9:0]);
      if (t == 2'b00) begin cyc += 2; exp_done = 1'b1; exp_code = 2'd0; break; end
      if (t == 2'b11) begin cyc += 2; exp_done = 1'b0; exp_code = 2'd1; break; end
      for (int k = 0; k < len; k++) begin
        a = (src + k) % 16384;
        w = (dst + k) % 1024;
        exp_rd.push_back(a[13:0]);
        exp_wr.push_back({(t == 2'b01), 5'd0, w[9:0], mem[a]});
        exp_sum += mem[a];
        if (exp_cnt < 65535) exp_cnt++;
      end
      cyc += (len == 0) ? 2 : 3 + len;
      if (idx == 255) begin exp_done = 1'b0; exp_code = 2'd2; break; end
      idx++;
    end
    exp_cycles = cyc;
  endtask

  task automatic run_check(input string nm);
    int n, busy_low, wr_base, rd_base, bs_base, nw, nr;
    model();
    wr_base  = wr_q.size();
    rd_base  = rd_q.size();
    bs_base  = bad_strobe;
    busy_low = 0;
    n        = 0;
    start    = 1'b1;
    while (n < exp_cycles + 40) begin
      @(posedge clk); #1;
      n++;
      if (done || error) break;
      if (!busy) busy_low++;
    end
    check_eq({nm, "/cycles"}, n, exp_cycles);
    check_eq({nm, "/done"}, done, exp_done);
    check_eq({nm, "/error"}, error, exp_code != 2'd0);
    check_eq({nm, "/err_code"}, err_code, exp_code);
    check_eq({nm, "/word_cnt"}, word_cnt, exp_cnt);
    check_eq({nm, "/checksum"}, checksum, exp_sum);
    check_eq({nm, "/busy_final"}, busy, 1'b0);
    check_eq({nm, "/busy_gaps"}, busy_low, 0);
    nw = wr_q.size() - wr_base;
    nr = rd_q.size() - rd_base;
    check_eq({nm, "/n_writes"}, nw, exp_wr.size());
    check_eq({nm, "/n_reads"}, nr, exp_rd.size());
    for (int k = 0; k < nw && k < exp_wr.size(); k++)
      check_eq($sformatf("%s/wr%0d", nm, k), wr_q[wr_base + k], exp_wr[k]);
    for (int k = 0; k < nr && k < exp_rd.size(); k++)
      check_eq($sformatf("%s/rd%0d", nm, k), rd_q[rd_base + k], exp_rd[k]);
    repeat (3) @(posedge clk);
    #1;
    check_eq({nm, "/hold"}, {done, error, err_code}, {exp_done, exp_code != 2'd0, exp_code});
    check_eq({nm, "/strobes"}, bad_strobe - bs_base, 0);
    start = 1'b0;
    @(posedge clk); #1;
    check_eq({nm, "/idle_status"}, {busy, done, error, err_code}, 5'd0);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = '0;
  endtask

  initial begin
    int nd;
    logic [1:0] t;
    for (int i = 0; i < 16384; i++) mem[i] = $urandom;
    for (int i = 0; i < 4; i++) mem[i] = i + 1;
    clear_rom();

    repeat (3) @(posedge clk);
    #1;
    check_eq("reset/strobes",
             {rom_enable, rom_read, MEM_en, MEM_read, MEM_write, IM_enable, IM_write, IM_read,
              DM_enable, DM_write, DM_read}, 11'd0);
    check_eq("reset/status", {busy, done, error, err_code}, 5'd0);
    check_eq("reset/counters", {word_cnt, checksum}, 48'd0);
    check_eq("reset/addr", {rom_address, MEM_addr, IM_address, DM_address}, 47'd0);
    check_eq("reset/data", {IM_in, DM_in}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    rom[0] = desc(2'b01, 14'h0, 10'h0, 10'd4);
    run_check("single_im");

    clear_rom();
    rom[0] = desc(2'b10, 14'h100, 10'h20, 10'd3);
    rom[1] = desc(2'b01, 14'h200, 10'h80, 10'd2);
    run_check("dm_then_im");

    clear_rom();
    rom[0] = desc(2'b01, 14'h10, 10'h10, 10'd0);
    rom[1] = desc(2'b11, 14'h10, 10'h10, 10'd5);
    rom[2] = desc(2'b01, 14'h10, 10'h10, 10'd5);
    run_check("reserved_tgt");

    for (int i = 0; i < 256; i++) rom[i] = desc((i % 2 == 0) ? 2'b01 : 2'b10, 14'h0, 10'h0, 10'd0);
    run_check("no_terminator");

    clear_rom();
    rom[0] = desc(2'b01, 14'h3FFE, 10'h3FF, 10'd3);
    run_check("wrap");

    for (int it = 0; it < 5; it++) begin
      clear_rom();
      nd = $urandom_range(1, 5);
      for (int i = 0; i < nd; i++) begin
        t = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(1, 2));
        rom[i] = desc(t, 14'($urandom), 10'($urandom), 10'($urandom_range(0, 24)));
      end
      run_check($sformatf("rand%0d", it));
    end

    clear_rom();
    rom[0] = desc(2'b01, 14'h0, 10'h0, 10'd4);
    rom[1] = desc(2'b10, 14'h40, 10'h8, 10'd6);
    start = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("midrst/strobes",
             {rom_enable, MEM_en, IM_enable, IM_write, DM_enable, DM_write}, 6'd0);
    check_eq("midrst/status", {busy, done, error, err_code}, 5'd0);
    check_eq("midrst/counters", {word_cnt, checksum}, 48'd0);
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    run_check("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
